mac3_operand_feeder: RTL

// - Upstream sequencer for the 3-input MAC: holds a KERNEL_ROWS x 3 weight bank plus a bias, and pairs each incoming

---
 rtl/mac3_operand_feeder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mac3_operand_feeder.sv
// Pairs activation triplets with a KERNEL_ROWS x 3 weight bank plus bias and sequences a 3-input MAC.
// Latency: operands 1 cycle after accept, result_valid 2 cycles after the last row's accept.
// Backpressure: act_ready low in DRAIN and in RESULT until result_ready; zero-skip via MAC3_FEEDER_ZERO_SKIP_EN.
module mac3_operand_feeder #(
  parameter int A_WIDTH           = 16,
  parameter int B_WIDTH           = 16,
  parameter int ACCUMULATOR_WIDTH = 32,
  parameter int KERNEL_ROWS       = 3,
  parameter int ROW_W             = (KERNEL_ROWS > 1) ? $clog2(KERNEL_ROWS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_in,
  input  logic                         wgt_we,
  input  logic [ROW_W-1:0]             wgt_row,
  input  logic [3*B_WIDTH-1:0]         wgt_data,
  input  logic                         bias_we,
  input  logic [ACCUMULATOR_WIDTH-1:0] bias_data,
  input  logic                         act_valid,
  output logic                         act_ready,
  input  logic [3*A_WIDTH-1:0]         act_data,
  output logic                         mac_input_valid,
  output logic                         mac_accumulate_internal,
  output logic [ACCUMULATOR_WIDTH-1:0] mac_partial_sum_in,
  output logic [A_WIDTH-1:0]           mac_a0,
  output logic [A_WIDTH-1:0]           mac_a1,
  output logic [A_WIDTH-1:0]           mac_a2,
  output logic [B_WIDTH-1:0]           mac_b0,
  output logic [B_WIDTH-1:0]           mac_b1,
  output logic [B_WIDTH-1:0]           mac_b2,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic                         busy,
  output logic                         wgt_ignored
`ifdef MAC3_FEEDER_ZERO_SKIP_EN
  ,
  output logic [15:0]                  skip_count
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, RESULT} state_t;

  localparam int DEPTH = 1 << ROW_W;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(KERNEL_ROWS - 1);
  // A single-row kernel finishes on its first accept, so it bypasses RUN.
  localparam state_t FIRST = (KERNEL_ROWS == 1) ? DRAIN : RUN;

  state_t                       state, state_nxt;
  logic [ROW_W-1:0]             row_cnt;
  logic [3*B_WIDTH-1:0]         wgt_bank [DEPTH];
  logic [ACCUMULATOR_WIDTH-1:0] bias_q;
  logic [3*A_WIDTH-1:0]         a_q;
  logic [3*B_WIDTH-1:0]         b_q;
  logic                         accept;
  logic                         skip;
  logic                         wgt_open;

  assign accept   = act_valid & act_ready;
  assign wgt_open = (state == IDLE) && !accept;

`ifdef MAC3_FEEDER_ZERO_SKIP_EN
  // Row 0 always issues so the MAC accumulator is (re)initialised with the bias.
  assign skip = (act_data == '0) && (row_cnt != '0);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = FIRST;
      RUN:     if (accept && row_cnt == LAST_ROW) state_nxt = DRAIN;
      DRAIN:   state_nxt = RESULT;
      RESULT:  if (result_ready) state_nxt = act_valid ? FIRST : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    act_ready    = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b1;
    case (state)
      IDLE: begin
        act_ready = 1'b1;
        busy      = 1'b0;
      end
      RUN:    act_ready = 1'b1;
      RESULT: begin
        result_valid = 1'b1;
        act_ready    = result_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      row_cnt                 <= '0;
      a_q                     <= '0;
      b_q                     <= '0;
      mac_input_valid         <= 1'b0;
      mac_accumulate_internal <= 1'b0;
      bias_q                  <= '0;
      wgt_ignored             <= 1'b0;
      for (int i = 0; i < DEPTH; i++) wgt_bank[i] <= '0;
    end else begin
      mac_input_valid <= accept & ~skip;
      if (accept) begin
        row_cnt                 <= (row_cnt == LAST_ROW) ? '0 : row_cnt + ROW_W'(1);
        a_q                     <= act_data;
        b_q                     <= wgt_bank[row_cnt];
        mac_accumulate_internal <= (row_cnt != '0);
      end
      if (wgt_we && wgt_open && int'(wgt_row) < KERNEL_ROWS) wgt_bank[wgt_row] <= wgt_data;
      if (bias_we && wgt_open) bias_q <= bias_data;
      if ((wgt_we || bias_we) && !wgt_open) wgt_ignored <= 1'b1;
    end
  end

`ifdef MAC3_FEEDER_ZERO_SKIP_EN
  always_ff @(posedge clk) begin
    if (rst_in) skip_count <= '0;
    else if (accept && skip && skip_count != 16'hFFFF) skip_count <= skip_count + 16'd1;
  end
`endif

  assign mac_partial_sum_in = bias_q;
  assign mac_a0 = a_q[0*A_WIDTH +: A_WIDTH];
  assign mac_a1 = a_q[1*A_WIDTH +: A_WIDTH];
  assign mac_a2 = a_q[2*A_WIDTH +: A_WIDTH];
  assign mac_b0 = b_q[0*B_WIDTH +: B_WIDTH];
  assign mac_b1 = b_q[1*B_WIDTH +: B_WIDTH];
  assign mac_b2 = b_q[2*B_WIDTH +: B_WIDTH];

endmodule
